multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-003 SHALL have port opcode  input  6  instruction[31:26] from the instruction register.
REQ-004 SHALL have port zero  input  1  ALU zero flag.
REQ-005 SHALL have port mem_ready  input  1  memory handshake; access completes in a cycle where it is 1.
REQ-006 SHALL have port pcwrite  output  1  unconditional PC load.
REQ-007 SHALL have port pcwritecond  output  1  PC load qualified by zero.
REQ-008 SHALL have port iord  output  1  memory address select (0=PC, 1=ALUOut).
REQ-009 SHALL have ports memread and memwrite  output  1 each  memory strobes.
REQ-010 SHALL have port irwrite  output  1  instruction register load.
REQ-011 SHALL have ports regdst, memtoreg and regwrite  output  1 each  register-file controls.
REQ-012 SHALL have ports alusrca (1 bit), alusrcb (2 bits) and pcsource (2 bits)  output  ALU-operand and PC-source selects.
REQ-013 SHALL have port aluop  output  3  ALU operation when rtype=0 (001 add, 101 sub, 000 or).
REQ-014 SHALL have port rtype  output  1  1 selects func-field decode in the ALU control.
REQ-015 SHALL have port illegal  output  1  one-cycle pulse on an unsupported opcode.
REQ-016 SHALL have port state  output  4  current FSM state, for debug.

Function
REQ-017 SHALL implement a Moore FSM: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXEC=6, RTWB=7, BRANCH=8, IMMEXEC=9, IMMWB=10, JUMP=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-018 FETCH SHALL drive memread=1, iord=0, alusrca=0, alusrcb=01, aluop=001, pcsource=00; irwrite and pcwrite SHALL be 1 only when mem_ready=1; the FSM SHALL stay in FETCH while mem_ready=0.
REQ-019 DECODE SHALL drive alusrca=0, alusrcb=11, aluop=001 (branch target) and branch on opcode: 100011/101011 to MEMADR, 000000 to RTEXEC, 000100 to BRANCH, 001101/001000 to IMMEXEC, 000010 to JUMP (see REQ-031), any other opcode to FETCH with illegal=1 for that one cycle.
REQ-020 MEMADR SHALL drive alusrca=1, alusrcb=10, aluop=001, then go to MEMRD if opcode=100011, else MEMWR.
REQ-021 MEMRD SHALL drive memread=1, iord=1 and hold until mem_ready=1, then go to MEMWB; MEMWB SHALL drive regwrite=1, memtoreg=1, regdst=0, then go to FETCH.
REQ-022 MEMWR SHALL drive iord=1 and memwrite=1 and hold until mem_ready=1, then go to FETCH.
REQ-023 RTEXEC SHALL drive alusrca=1, alusrcb=00, rtype=1; RTWB SHALL drive regwrite=1, regdst=1, memtoreg=0, then go to FETCH.
REQ-024 BRANCH SHALL drive alusrca=1, alusrcb=00, aluop=101, pcsource=01, pcwritecond=1, then go to FETCH; the PC loads only when zero=1.
REQ-025 IMMEXEC SHALL drive alusrca=1, alusrcb=10, aluop=000 for 001101 (ori) and 001 for 001000 (addi); IMMWB SHALL drive regwrite=1, regdst=0, memtoreg=0.
REQ-026 Outputs not listed for a state SHALL be 0; rtype SHALL be 0 outside RTEXEC; at most one of memread or memwrite SHALL be 1 in any cycle.
REQ-027 Instruction latency with mem_ready tied to 1 SHALL be: lw 5 cycles, sw 4, R-type 4, ori/addi 4, beq 3, j 3.
REQ-028 opcode SHALL be sampled only in DECODE, MEMADR and IMMEXEC; opcode changes in other states SHALL have no effect.

Reset
REQ-029 While rstn=0, state SHALL be FETCH and all registered outputs SHALL be 0, regardless of clk; reset asserted mid-instruction (e.g. in MEMWR) SHALL abort it, and no strobe SHALL remain asserted during reset.
REQ-030 On the first rising edge after rstn rises, the FSM SHALL evaluate FETCH normally.

Configuration
REQ-031 With MULTICYCLE_JUMP_EN defined, opcode 000010 SHALL go to JUMP (pcwrite=1, pcsource=10, then FETCH); without it, 000010 SHALL be treated as illegal and JUMP SHALL be unreachable.

Verification
REQ-032 rstn=0 then released, mem_ready=1, opcode=100011 -> state sequence 0,1,2,3,4,0 and regwrite=1 with memtoreg=1 in state 4.
REQ-033 opcode=101011, mem_ready held 0 for 3 cycles in MEMWR -> memwrite=1 for 4 cycles and state 5 held until mem_ready=1, then state 0.
REQ-034 opcode=000000 -> rtype=1 only in state 6 and regwrite=1 with regdst=1 in state 7; opcode=000100, zero=0 -> pcwritecond=1 and pcwrite=0 in state 8.
REQ-035 opcode=111111 -> illegal=1 for exactly one cycle in DECODE, then state 0, with no regwrite or memwrite asserted.
REQ-036 rstn pulsed low in MEMRD between clock edges -> state=0 and memread=0 immediately; with and without MULTICYCLE_JUMP_EN, opcode=000010 -> states 1 then 11 versus illegal=1.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM (Moore states; FETCH strobes qualified by mem_ready).
// Optional jump support: define MULTICYCLE_JUMP_EN to make opcode 000010 reach JUMP.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rstn,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic [2:0] aluop,
  output logic       rtype,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTEXEC  = 4'd6,
    RTWB    = 4'd7,
    BRANCH  = 4'd8,
    IMMEXEC = 4'd9,
    IMMWB   = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MULTICYCLE_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  state_t cur, nxt;

  // The branch decision (pcwritecond & zero) is formed in the datapath.
  logic zero_unused;
  assign zero_unused = zero;

  assign state = cur;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cur <= FETCH;
    else       cur <= nxt;
  end

  // Outputs are forced low while rstn is low so FETCH's memread cannot leak out.
  always_comb begin
    nxt         = cur;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = '0;
    pcsource    = '0;
    aluop       = '0;
    rtype       = 1'b0;
    illegal     = 1'b0;
    if (rstn) begin
      case (cur)
        FETCH: begin
          memread = 1'b1;
          alusrcb = 2'b01;
          aluop   = 3'b001;
          if (mem_ready) begin
            irwrite = 1'b1;
            pcwrite = 1'b1;
            nxt     = DECODE;
          end
        end
        DECODE: begin
          alusrcb = 2'b11;
          aluop   = 3'b001;
          case (opcode)
            OP_LW, OP_SW:    nxt = MEMADR;
            OP_RTYPE:        nxt = RTEXEC;
            OP_BEQ:          nxt = BRANCH;
            OP_ORI, OP_ADDI: nxt = IMMEXEC;
`ifdef MULTICYCLE_JUMP_EN
            OP_J:            nxt = JUMP;
`endif
            default: begin
              nxt     = FETCH;
              illegal = 1'b1;
            end
          endcase
        end
        MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          aluop   = 3'b001;
          nxt     = (opcode == OP_LW) ? MEMRD : MEMWR;
        end
        MEMRD: begin
          memread = 1'b1;
          iord    = 1'b1;
          if (mem_ready) nxt = MEMWB;
        end
        MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
          nxt      = FETCH;
        end
        MEMWR: begin
          iord     = 1'b1;
          memwrite = 1'b1;
          if (mem_ready) nxt = FETCH;
        end
        RTEXEC: begin
          alusrca = 1'b1;
          rtype   = 1'b1;
          nxt     = RTWB;
        end
        RTWB: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
          nxt      = FETCH;
        end
        BRANCH: begin
          alusrca     = 1'b1;
          aluop       = 3'b101;
          pcsource    = 2'b01;
          pcwritecond = 1'b1;
          nxt         = FETCH;
        end
        IMMEXEC: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          aluop   = (opcode == OP_ORI) ? 3'b000 : 3'b001;
          nxt     = IMMWB;
        end
        IMMWB: begin
          regwrite = 1'b1;
          nxt      = FETCH;
        end
        JUMP: begin
`ifdef MULTICYCLE_JUMP_EN
          pcwrite  = 1'b1;
          pcsource = 2'b10;
`endif
          nxt = FETCH;
        end
        default: nxt = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: random instruction stream expanded into per-cycle expected controls.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       regdst, memtoreg, regwrite, alusrca, rtype, illegal;
  logic [1:0] alusrcb, pcsource;
  logic [2:0] aluop;
  logic [3:0] state;

  multicycle_ctrl dut (
    .clk(clk), .rstn(rstn), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
    .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsource(pcsource),
    .aluop(aluop), .rtype(rtype), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsource;
    logic [2:0] aluop;
    logic rtype, illegal;
  } vec_t;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_IMM = 4, K_J = 5, K_ILL = 6;

  vec_t exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t actual();
    vec_t v;
    v = {state, pcwrite, pcwritecond, iord, memread, memwrite, irwrite, regdst,
         memtoreg, regwrite, alusrca, alusrcb, pcsource, aluop, rtype, illegal};
    return v;
  endfunction

  task automatic check(input string name, input vec_t got, input vec_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got state=%0d ctl=%05h, expected state=%0d ctl=%05h",
               name, got.st, got[18:0], want.st, want[18:0]);
    end
  endtask

  function automatic vec_t base(input logic [3:0] st);
    vec_t v = '0;
    v.st = st;
    return v;
  endfunction

  function automatic int classify(input logic [5:0] op);
    case (op)
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000000: return K_R;
      6'b000100: return K_BEQ;
      6'b001101, 6'b001000: return K_IMM;
`ifdef MULTICYCLE_JUMP_EN
      6'b000010: return K_J;
`endif
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [5:0] junk();
    return 6'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cyc(input vec_t e, input logic mr, input logic [5:0] op);
    mem_ready = mr;
    opcode    = op;
    zero      = rbit();
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t v_fetch(input logic done);
    vec_t v = base(4'd0);
    v.memread = 1'b1; v.alusrcb = 2'b01; v.aluop = 3'b001;
    v.irwrite = done; v.pcwrite = done;
    return v;
  endfunction

  function automatic vec_t v_decode(input logic bad);
    vec_t v = base(4'd1);
    v.alusrcb = 2'b11; v.aluop = 3'b001; v.illegal = bad;
    return v;
  endfunction

  function automatic vec_t v_memadr();
    vec_t v = base(4'd2);
    v.alusrca = 1'b1; v.alusrcb = 2'b10; v.aluop = 3'b001;
    return v;
  endfunction

  function automatic vec_t v_memrd();
    vec_t v = base(4'd3);
    v.memread = 1'b1; v.iord = 1'b1;
    return v;
  endfunction

  // One whole instruction: fetch stalls fs cycles, memory phase stalls ms cycles.
  task automatic run_instr(input logic [5:0] op, input int fs, input int ms);
    vec_t v;
    int k;
    k = classify(op);
    for (int i = 0; i < fs; i++) cyc(v_fetch(1'b0), 1'b0, junk());
    cyc(v_fetch(1'b1), 1'b1, junk());
    cyc(v_decode(k == K_ILL), rbit(), op);
    case (k)
      K_LW: begin
        cyc(v_memadr(), rbit(), op);
        for (int i = 0; i < ms; i++) cyc(v_memrd(), 1'b0, junk());
        cyc(v_memrd(), 1'b1, junk());
        v = base(4'd4); v.regwrite = 1'b1; v.memtoreg = 1'b1;
        cyc(v, rbit(), junk());
      end
      K_SW: begin
        cyc(v_memadr(), rbit(), op);
        v = base(4'd5); v.iord = 1'b1; v.memwrite = 1'b1;
        for (int i = 0; i < ms; i++) cyc(v, 1'b0, junk());
        cyc(v, 1'b1, junk());
      end
      K_R: begin
        v = base(4'd6); v.alusrca = 1'b1; v.rtype = 1'b1;
        cyc(v, rbit(), junk());
        v = base(4'd7); v.regwrite = 1'b1; v.regdst = 1'b1;
        cyc(v, rbit(), junk());
      end
      K_BEQ: begin
        v = base(4'd8); v.alusrca = 1'b1; v.aluop = 3'b101;
        v.pcsource = 2'b01; v.pcwritecond = 1'b1;
        cyc(v, rbit(), junk());
      end
      K_IMM: begin
        v = base(4'd9); v.alusrca = 1'b1; v.alusrcb = 2'b10;
        v.aluop = (op == 6'b001101) ? 3'b000 : 3'b001;
        cyc(v, rbit(), op);
        v = base(4'd10); v.regwrite = 1'b1;
        cyc(v, rbit(), junk());
      end
      K_J: begin
        v = base(4'd11); v.pcwrite = 1'b1; v.pcsource = 2'b10;
        cyc(v, rbit(), junk());
      end
      default: ;
    endcase
  endtask

  initial begin : monitor
    vec_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("ctl_state%0d", e.st), actual(), e);
      end
    end
  end

  initial begin : driver
    logic [5:0] ops [8];
    logic [5:0] op;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
            6'b001101, 6'b001000, 6'b000010, 6'b111111};

    // Reset held with mem_ready high: FETCH strobes must stay suppressed.
    mem_ready = 1'b1;
    #3 check("reset_init", actual(), base(4'd0));
    @(posedge clk); #1;
    check("reset_hold_edge", actual(), base(4'd0));
    @(negedge clk);
    mem_ready = 1'b0;
    rstn = 1'b1;
    @(posedge clk); #1;

    run_instr(6'b100011, 0, 0);
    run_instr(6'b101011, 0, 3);
    run_instr(6'b000000, 0, 0);
    run_instr(6'b000100, 1, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b001101, 2, 0);
    run_instr(6'b001000, 0, 0);

    // Asynchronous reset arriving mid-MEMRD, between clock edges.
    cyc(v_fetch(1'b1), 1'b1, junk());
    cyc(v_decode(1'b0), rbit(), 6'b100011);
    cyc(v_memadr(), rbit(), 6'b100011);
    mem_ready = 1'b0;
    opcode = junk();
    exp_q.push_back(v_memrd());
    @(negedge clk);
    #2 rstn = 1'b0;
    mem_ready = 1'b1;
    #1 check("reset_in_memrd", actual(), base(4'd0));
    @(posedge clk); #1;
    check("reset_in_memrd_edge", actual(), base(4'd0));
    @(negedge clk);
    mem_ready = 1'b0;
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) op = junk();
      else op = ops[$urandom_range(0, 7)];
      run_instr(op,
                ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
                ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)));
    end

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected cycles left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
